alu_ext_seq: RTL and testbench
==============================

Name: alu_ext_seq

Overview:
- Sequencer for the extended ALU datapath. That datapath provides MUL, UMUL, ADDF, SUBF, MULF, ITF and FTI, selected by a 3-bit func.
- Accepts one operation per request from the EX stage and latches the operands and func onto the datapath.
- Counts a per-class latency, then captures the 32-bit result and the ov/zr/neg flags.
- Stalls the pipeline while the operation is in flight, and pulses done when the result is ready for the EX/DM register.

Parameters:
- LAT_IMUL, 2, EXEC cycles for func 000/001 (MUL, UMUL); legal range 1..15.
- LAT_FADD, 3, EXEC cycles for func 010/011 (ADDF, SUBF); 1..15.
- LAT_FMUL, 3, EXEC cycles for func 100 (MULF); 1..15.
- LAT_CVT, 2, EXEC cycles for func 101/110 (ITF, FTI); 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX stage requests an extended-ALU operation this cycle.
- func  input  3  operation code, encoded as in the extended ALU (111 is undefined).
- src1  input  32  operand 1.
- src0  input  32  operand 0.
- flush  input  1  pipeline flush; aborts any in-flight operation.
- unit_dst  input  32  result from the datapath.
- unit_ov  input  1  overflow flag from the datapath.
- unit_zr  input  1  zero flag from the datapath.
- unit_neg  input  1  negative flag from the datapath.
- op_src1  output  32  registered operand 1 to the datapath.
- op_src0  output  32  registered operand 0 to the datapath.
- op_func  output  3  registered func to the datapath.
- stall  output  1  freezes the IF/ID/EX pipeline registers (combinational).
- busy  output  1  high while state is EXEC.
- done  output  1  one-cycle pulse; result and flags valid.
- dst  output  32  captured result.
- ov  output  1  captured overflow flag.
- zr  output  1  captured zero flag.
- neg  output  1  captured negative flag.
- illegal  output  1  high together with done when func was 111.

Behaviour:
- Reset:
  - state = IDLE; cnt = 0.
  - op_src1, op_src0, dst = 0; op_func = 000.
  - done, illegal, ov, zr, neg, busy = 0.
  - rst has priority over every other input; reset in the middle of an operation discards it and produces no done pulse.
- States: IDLE, EXEC, DONE. cnt is a 4-bit down-counter.
- Accepting a request:
  - A request is accepted when start=1 and state is IDLE or DONE.
  - On the next edge: op_src1 <= src1, op_src0 <= src0, op_func <= func, cnt <= LAT(func) - 1, state <= EXEC.
  - LAT(func) is selected per the parameter table above.
- EXEC:
  - op_* registers are held stable.
  - If cnt != 0: cnt decrements each cycle.
  - If cnt == 0: on the next edge dst <= unit_dst, {ov,zr,neg} <= {unit_ov,unit_zr,unit_neg}, illegal <= 0, state <= DONE.
  - start is ignored in EXEC.
- Latency: with start accepted in cycle T, EXEC occupies cycles T+1 .. T+LAT and done=1 in cycle T+LAT+1.
- DONE:
  - done=1 for exactly one cycle; dst and flags hold their values until the next capture.
  - A start in DONE is accepted (back-to-back operations); otherwise state -> IDLE.
  - busy=0 in DONE.
- Illegal func 111 accepted:
  - Goes directly to DONE on the next edge and skips EXEC.
  - dst <= 0, ov <= 0, zr <= 1, neg <= 0, illegal <= 1.
  - op_* registers are not updated.
- stall = (start & (state==IDLE | state==DONE) & func!=111) | (state==EXEC).
  - stall is low in the DONE cycle so the EX/DM register captures dst.
- flush:
  - In EXEC: next state = IDLE, no done pulse, dst and flags unchanged.
  - Flush in the same cycle as start: the request is not accepted.
  - flush has priority over start and over a cnt==0 capture.
- done is low in every cycle other than the single DONE cycle.

Test Plan:
1. Reset, then start in cycle 0 with func=000, src1=3, src0=0xFFFFFFFE; model drives unit_dst=0xFFFFFFFA, unit_neg=1 -> op_src1=3 from cycle 1; stall=1 in cycles 0..2; done=1 in cycle 3 only; dst=0xFFFFFFFA, neg=1, zr=0.
2. Start func=010 (ADDF), src1=0x3F800000, src0=0x40000000; model drives 0x40400000 -> done in cycle 4 (LAT_FADD=3); dst=0x40400000; busy=1 in cycles 1..3.
3. Back-to-back: start func=101 (ITF) in cycle 0, then start func=110 (FTI) in the DONE cycle 3 -> second op accepted with no IDLE gap; second done in cycle 6; op_func=110 from cycle 4.
4. Start func=111 -> done=1 and illegal=1 in cycle 1; dst=0, zr=1, stall=0 in cycle 0; op_func unchanged.
5. Start func=100 (MULF), assert flush in cycle 2 -> state IDLE in cycle 3; no done through cycle 10; dst retains its prior value.
6. Start func=001 (UMUL), assert rst in cycle 1 -> all outputs 0 in cycle 2; no done pulse follows.

Source files
------------

// File: rtl/alu_ext_seq.sv
// Sequencer for the extended ALU datapath: latches one operation, waits a per-class
// latency, captures result and flags, and stalls the pipeline while the op is in flight.
module alu_ext_seq #(
    parameter int unsigned LAT_IMUL = 2,
    parameter int unsigned LAT_FADD = 3,
    parameter int unsigned LAT_FMUL = 3,
    parameter int unsigned LAT_CVT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  func,
    input  logic [31:0] src1,
    input  logic [31:0] src0,
    input  logic        flush,
    input  logic [31:0] unit_dst,
    input  logic        unit_ov,
    input  logic        unit_zr,
    input  logic        unit_neg,
    output logic [31:0] op_src1,
    output logic [31:0] op_src0,
    output logic [2:0]  op_func,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] dst,
    output logic        ov,
    output logic        zr,
    output logic        neg,
    output logic        illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_IMUL_C = 4'(LAT_IMUL);
    localparam logic [3:0] LAT_FADD_C = 4'(LAT_FADD);
    localparam logic [3:0] LAT_FMUL_C = 4'(LAT_FMUL);
    localparam logic [3:0] LAT_CVT_C  = 4'(LAT_CVT);
    localparam logic [2:0] FUNC_ILL   = 3'b111;

    // Counter preload is latency minus one so cnt==0 marks the final EXEC cycle.
    function automatic logic [3:0] lat_preload(input logic [2:0] f);
        logic [3:0] lat;
        case (f)
            3'b000, 3'b001: lat = LAT_IMUL_C;
            3'b010, 3'b011: lat = LAT_FADD_C;
            3'b100:         lat = LAT_FMUL_C;
            3'b101, 3'b110: lat = LAT_CVT_C;
            default:        lat = 4'd1;
        endcase
        return lat - 4'd1;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op_src1_q, op_src1_d;
    logic [31:0] op_src0_q, op_src0_d;
    logic [2:0]  op_func_q, op_func_d;
    logic [31:0] dst_q, dst_d;
    logic        ov_q, ov_d;
    logic        zr_q, zr_d;
    logic        neg_q, neg_d;
    logic        ill_q, ill_d;
    logic        ready_s;
    logic        accept_s;

    assign ready_s  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept_s = start && ready_s && !flush;

    // Next-state, counter and capture logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_src1_d = op_src1_q;
        op_src0_d = op_src0_q;
        op_func_d = op_func_q;
        dst_d     = dst_q;
        ov_d      = ov_q;
        zr_d      = zr_q;
        neg_d     = neg_q;
        ill_d     = ill_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    if (func == FUNC_ILL) begin
                        state_d = ST_DONE;
                        dst_d   = 32'd0;
                        ov_d    = 1'b0;
                        zr_d    = 1'b1;
                        neg_d   = 1'b0;
                        ill_d   = 1'b1;
                    end else begin
                        state_d   = ST_EXEC;
                        cnt_d     = lat_preload(func);
                        op_src1_d = src1;
                        op_src0_d = src0;
                        op_func_d = func;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                    dst_d   = unit_dst;
                    ov_d    = unit_ov;
                    zr_d    = unit_zr;
                    neg_d   = unit_neg;
                    ill_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_src1_q <= 32'd0;
            op_src0_q <= 32'd0;
            op_func_q <= 3'd0;
            dst_q     <= 32'd0;
            ov_q      <= 1'b0;
            zr_q      <= 1'b0;
            neg_q     <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_src1_q <= op_src1_d;
            op_src0_q <= op_src0_d;
            op_func_q <= op_func_d;
            dst_q     <= dst_d;
            ov_q      <= ov_d;
            zr_q      <= zr_d;
            neg_q     <= neg_d;
            ill_q     <= ill_d;
        end
    end

    // Stall drops in DONE so the EX/DM register can take the result.
    assign stall   = (start && ready_s && (func != FUNC_ILL)) || (state_q == ST_EXEC);
    assign busy    = (state_q == ST_EXEC);
    assign done    = (state_q == ST_DONE);
    assign illegal = (state_q == ST_DONE) && ill_q;
    assign op_src1 = op_src1_q;
    assign op_src0 = op_src0_q;
    assign op_func = op_func_q;
    assign dst     = dst_q;
    assign ov      = ov_q;
    assign zr      = zr_q;
    assign neg     = neg_q;

endmodule

// File: tb/tb_alu_ext_seq.sv
// Randomised and directed bench for alu_ext_seq against a timestamp-based reference model.
module tb_alu_ext_seq;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  func;
    logic [31:0] src1, src0, unit_dst;
    logic        unit_ov, unit_zr, unit_neg;
    logic [31:0] op_src1, op_src0, dst;
    logic [2:0]  op_func;
    logic        stall, busy, done, ov, zr, neg, illegal;

    alu_ext_seq dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .src1(src1), .src0(src0),
        .flush(flush), .unit_dst(unit_dst), .unit_ov(unit_ov), .unit_zr(unit_zr),
        .unit_neg(unit_neg), .op_src1(op_src1), .op_src0(op_src0), .op_func(op_func),
        .stall(stall), .busy(busy), .done(done), .dst(dst), .ov(ov), .zr(zr),
        .neg(neg), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: an in-flight op is described by the cycle of its last EXEC beat.
    bit          m_inflight = 1'b0;
    int          m_end      = 0;
    bit          m_done     = 1'b0;
    bit          m_ill      = 1'b0;
    logic [31:0] m_dst = 32'd0, m_op1 = 32'd0, m_op0 = 32'd0;
    logic [2:0]  m_func = 3'd0;
    logic        m_ov = 1'b0, m_zr = 1'b0, m_neg = 1'b0;

    // Observations used by the directed literal checks.
    int last_done = -1;
    int n_done = 0, n_stall = 0, n_busy = 0, n_ill = 0;

    function automatic int lat_of(input logic [2:0] f);
        if (f <= 3'd1) return 2;
        if (f <= 3'd3) return 3;
        if (f == 3'd4) return 3;
        return 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit nd = 1'b0;
        if (rst) begin
            m_inflight = 1'b0; m_ill = 1'b0;
            m_dst = 32'd0; m_op1 = 32'd0; m_op0 = 32'd0; m_func = 3'd0;
            m_ov = 1'b0; m_zr = 1'b0; m_neg = 1'b0;
        end else if (m_inflight) begin
            if (flush) begin
                m_inflight = 1'b0;
            end else if (cyc == m_end) begin
                m_inflight = 1'b0;
                m_dst = unit_dst; m_ov = unit_ov; m_zr = unit_zr; m_neg = unit_neg;
                m_ill = 1'b0; nd = 1'b1;
            end
        end else if (start && !flush) begin
            if (func == 3'b111) begin
                m_dst = 32'd0; m_ov = 1'b0; m_zr = 1'b1; m_neg = 1'b0;
                m_ill = 1'b1; nd = 1'b1;
            end else begin
                m_op1 = src1; m_op0 = src0; m_func = func;
                m_inflight = 1'b1; m_end = cyc + lat_of(func);
            end
        end
        m_done = nd;
    endtask

    // One cycle: compare mid-cycle, advance the model, then cross the rising edge.
    task automatic tick();
        #2;
        chk("stall", {31'd0, stall}, {31'd0, (start && !m_inflight && func != 3'b111) || m_inflight});
        chk("busy", {31'd0, busy}, {31'd0, m_inflight});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("illegal", {31'd0, illegal}, {31'd0, m_done && m_ill});
        chk("dst", dst, m_dst);
        chk("flags", {29'd0, ov, zr, neg}, {29'd0, m_ov, m_zr, m_neg});
        chk("op_src1", op_src1, m_op1);
        chk("op_src0", op_src0, m_op0);
        chk("op_func", {29'd0, op_func}, {29'd0, m_func});
        if (done === 1'b1) begin last_done = cyc; n_done++; end
        if (stall === 1'b1) n_stall++;
        if (busy === 1'b1) n_busy++;
        if (illegal === 1'b1) n_ill++;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_in();
        start = 1'b0; flush = 1'b0; rst = 1'b0; func = 3'd0;
    endtask

    task automatic clr_obs();
        last_done = -1; n_done = 0; n_stall = 0; n_busy = 0; n_ill = 0;
    endtask

    initial begin
        int t0;
        idle_in();
        rst = 1'b1; src1 = 32'd0; src0 = 32'd0;
        unit_dst = 32'd0; unit_ov = 1'b0; unit_zr = 1'b0; unit_neg = 1'b0;
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        chk("reset_dst", dst, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        tick();

        // 1: MUL, LAT 2
        clr_obs();
        start = 1'b1; func = 3'b000; src1 = 32'd3; src0 = 32'hFFFF_FFFE;
        unit_dst = 32'hFFFF_FFFA; unit_neg = 1'b1; unit_zr = 1'b0; unit_ov = 1'b0;
        t0 = cyc; tick(); idle_in();
        repeat (3) tick();
        chk("t1_done_cycle", last_done - t0, 32'd3);
        chk("t1_stall_cycles", n_stall, 32'd3);
        chk("t1_dst", dst, 32'hFFFF_FFFA);
        chk("t1_neg_zr", {30'd0, neg, zr}, 32'd2);
        chk("t1_op_src1", op_src1, 32'd3);

        // 2: ADDF, LAT 3
        clr_obs();
        start = 1'b1; func = 3'b010; src1 = 32'h3F80_0000; src0 = 32'h4000_0000;
        unit_dst = 32'h4040_0000; unit_neg = 1'b0;
        t0 = cyc; tick(); idle_in();
        repeat (4) tick();
        chk("t2_done_cycle", last_done - t0, 32'd4);
        chk("t2_busy_cycles", n_busy, 32'd3);
        chk("t2_dst", dst, 32'h4040_0000);

        // 3: ITF then FTI started in the DONE cycle
        clr_obs();
        start = 1'b1; func = 3'b101; unit_dst = 32'h4120_0000;
        t0 = cyc; tick(); idle_in();
        repeat (2) tick();
        start = 1'b1; func = 3'b110; src1 = 32'h4120_0000; unit_dst = 32'd10;
        tick(); idle_in();
        repeat (3) tick();
        chk("t3_done_count", n_done, 32'd2);
        chk("t3_second_done", last_done - t0, 32'd6);
        chk("t3_op_func", {29'd0, op_func}, 32'd6);
        chk("t3_dst", dst, 32'd10);

        // 4: illegal func
        clr_obs();
        start = 1'b1; func = 3'b111;
        t0 = cyc; tick(); idle_in();
        chk("t4_stall_c0", n_stall, 32'd0);
        tick();
        chk("t4_done_cycle", last_done - t0, 32'd1);
        chk("t4_illegal_seen", n_ill, 32'd1);
        chk("t4_dst_zr", {dst[30:0], zr}, 32'd1);
        chk("t4_op_func", {29'd0, op_func}, 32'd6);
        tick();

        // 5: MULF flushed in its second EXEC cycle
        clr_obs();
        start = 1'b1; func = 3'b100; unit_dst = 32'h1234_5678;
        tick(); idle_in();
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t5_busy_after_flush", {31'd0, busy}, 32'd0);
        repeat (8) tick();
        chk("t5_no_done", n_done, 32'd0);
        chk("t5_dst_kept", dst, 32'd0);

        // 6: UMUL interrupted by reset
        clr_obs();
        start = 1'b1; func = 3'b001; src1 = 32'hDEAD_BEEF;
        tick(); idle_in();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_op_src1_reset", op_src1, 32'd0);
        repeat (5) tick();
        chk("t6_no_done", n_done, 32'd0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            start    = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 24) == 0);
            func     = ($urandom_range(0, 15) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            src1     = $urandom;
            src0     = $urandom;
            unit_dst = $urandom;
            unit_ov  = 1'($urandom_range(0, 1));
            unit_zr  = 1'($urandom_range(0, 1));
            unit_neg = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
